// File: rtl/mant_div_pkg.sv
// Shared constants for the restoring mantissa divider: state codes and default sizing.
package mant_div_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam int MANT_DIV_WIDTH = 24;
  localparam int MANT_DIV_CNT_W = $clog2(MANT_DIV_WIDTH);

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell, the borrow-chain counterpart of the full adder.
module full_subtractor (
  output logic diff,
  output logic b_out,
  input  logic a,
  input  logic b,
  input  logic b_in
);

  assign diff  = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/mant_divider.sv
// Multi-cycle restoring unsigned divider, one quotient bit per clock.
// Optional MANT_DIV_STICKY_EN adds a registered sticky output (OR of the final remainder).
module mant_divider
  import mant_div_pkg::*;
#(
  parameter int WIDTH = MANT_DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
`ifdef MANT_DIV_STICKY_EN
  output logic             sticky,
`endif
  output logic             div_by_zero
);

  localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
`ifdef MANT_DIV_STICKY_EN
  logic             sticky_q, sticky_d;
`endif

  logic [WIDTH:0]   shiftRem;
  logic [WIDTH:0]   subtrahend;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] borrow;
  logic             fitsTrial;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;
  logic             unused_trial_msb;

  // The partial remainder is kept WIDTH bits wide; only the trial needs the extra bit.
  assign shiftRem   = {rem_q, quo_q[WIDTH-1]};
  assign subtrahend = {1'b0, divisor_q};
  assign borrow[0]  = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_borrow_chain
    full_subtractor u_fs (
      .diff (trial[i]),
      .b_out(borrow[i+1]),
      .a    (shiftRem[i]),
      .b    (subtrahend[i]),
      .b_in (borrow[i])
    );
  end

  assign fitsTrial        = ~borrow[WIDTH+1];
  assign unused_trial_msb = trial[WIDTH];
  assign remNext          = fitsTrial ? trial[WIDTH-1:0] : shiftRem[WIDTH-1:0];
  assign quoNext          = {quo_q[WIDTH-2:0], fitsTrial};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef MANT_DIV_STICKY_EN
    sticky_d    = sticky_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          divisor_d = divisor;
          if (divisor != '0) begin
            rem_d   = '0;
            quo_d   = dividend;
            cnt_d   = CntW'(WIDTH - 1);
            state_d = RUN;
          end else begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
`ifdef MANT_DIV_STICKY_EN
            sticky_d    = 1'b0;
`endif
            state_d     = DONE;
          end
        end
      end
      RUN: begin
        rem_d = remNext;
        quo_d = quoNext;
        cnt_d = cnt_q - 1'b1;
        // Results are latched on the way into DONE so they are valid with the done pulse.
        if (cnt_q == '0) begin
          quotient_d  = quoNext;
          remainder_d = remNext;
          dbz_d       = 1'b0;
`ifdef MANT_DIV_STICKY_EN
          sticky_d    = |remNext;
`endif
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef MANT_DIV_STICKY_EN
      sticky_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef MANT_DIV_STICKY_EN
      sticky_q    <= sticky_d;
`endif
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
`ifdef MANT_DIV_STICKY_EN
  assign sticky      = sticky_q;
`endif

endmodule
